// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage constants and exception codes
package mips_pkg;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6ffc;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - sequential fetch address adder (pc + 4, wraps modulo 2^32)
module pc_incr (
  input  logic [31:0] pc,
  output logic [31:0] pc4
);
  assign pc4 = pc + 32'd4;
endmodule

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - fetch PC register and next-PC priority mux
// Optional AdEL fetch check enabled by IFU_ADEL_CHECK_EN.
module ifu_pc #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR,
  parameter logic [31:0] IM_LO      = mips_pkg::IM_LO,
  parameter logic [31:0] IM_HI      = mips_pkg::IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_enter,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        redir_pend,
  output logic        fetch_exc,
  output logic [4:0]  fetch_exccode
);
  import mips_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  pc_incr u_pc_incr (
    .pc  (pc_q),
    .pc4 (pc4)
  );

  // Exception entry and eret bypass the stall; a redirect seen under stall is parked.
  always_comb begin
    pc_d       = pc4;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_enter) begin
      pc_d   = EXC_VECTOR;
      pend_d = 1'b0;
    end else if (eret) begin
      pc_d   = epc;
      pend_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
      if (br_taken) begin
        pend_tgt_d = br_target;
        pend_d     = 1'b1;
      end
    end else if (br_taken) begin
      pc_d   = br_target;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc         = pc_q;
  assign redir_pend = pend_q;

`ifdef IFU_ADEL_CHECK_EN
  assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
`else
  // Bounds only matter with the check built in; keep them referenced.
  logic unused_bounds;
  assign unused_bounds = &{1'b0, IM_LO, IM_HI};
  assign fetch_exc     = 1'b0;
`endif

  assign fetch_exccode = fetch_exc ? EXC_ADEL : 5'd0;
endmodule

// File: tb/tb_ifu_pc.sv
// tb/tb_ifu_pc.sv - self-checking bench for ifu_pc against a next-PC reference model
module tb_ifu_pc;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, exc_enter, eret;
  logic [31:0] br_target, epc, pc, pc4;
  logic        redir_pend, fetch_exc;
  logic [4:0]  fetch_exccode;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_tgt;
  logic        m_pend;

  ifu_pc dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .exc_enter     (exc_enter),
    .eret          (eret),
    .epc           (epc),
    .pc            (pc),
    .pc4           (pc4),
    .redir_pend    (redir_pend),
    .fetch_exc     (fetch_exc),
    .fetch_exccode (fetch_exccode)
  );

  always #5 clk = ~clk;

  function automatic logic exp_adel(input logic [31:0] a);
`ifdef IFU_ADEL_CHECK_EN
    return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_pend = 1'b0; m_tgt = 32'd0;
  endtask

  // Reference: the six-level priority list, evaluated on the inputs present at the edge.
  task automatic model_step();
    if (exc_enter) begin
      m_pc = 32'h0000_4180; m_pend = 1'b0;
    end else if (eret) begin
      m_pc = epc; m_pend = 1'b0;
    end else if (stall) begin
      if (br_taken) begin m_tgt = br_target; m_pend = 1'b1; end
    end else if (br_taken) begin
      m_pc = br_target; m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; exc_enter = 0; eret = 0;
    br_target = 32'd0; epc = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    model_reset();
    #12;
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h3000); end
    checks++; if (pc4 !== 32'h0000_3004) begin errors++; $display("FAIL reset_pc4 got=%h want=%h", pc4, 32'h3004); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL reset_pend got=%b want=0", redir_pend); end
    checks++; if (fetch_exc !== 1'b0) begin errors++; $display("FAIL reset_fexc got=%b want=0", fetch_exc); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] want [3];
    want[0] = 32'h3004; want[1] = 32'h3008; want[2] = 32'h300c;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== want[i]) begin errors++; $display("FAIL seq_pc%0d got=%h want=%h", i, pc, want[i]); end
    end
  endtask

  task automatic test_branch();
    idle(); br_taken = 1; br_target = 32'h3040;
    tick(); idle();
    checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL branch_pc got=%h want=%h", pc, 32'h3040); end
    checks++; if (redir_pend !== 1'b0) begin errors++; $display("FAIL branch_pend got=%b want=0", redir_pend); end
  endtask

  task automatic test_stall_redirect();
    idle(); stall = 1; br_taken = 1; br_target = 32'h3100;
    tick(); br_taken = 0; br_target = 32'h0;
    checks++; if (pc !== 32'h3040 || redir_pend !== 1'b1) begin errors++; $display("FAIL stall1 got=%h/%b want=%h/1", pc, redir_pend, 32'h3040); end
    tick(); stall = 0;
    checks++; if (pc !== 32'h3040 || redir_pend !== 1'b1) begin errors++; $display("FAIL stall2 got=%h/%b want=%h/1", pc, redir_pend, 32'h3040); end
    tick();
    checks++; if (pc !== 32'h3100 || redir_pend !== 1'b0) begin errors++; $display("FAIL stall_release got=%h/%b want=%h/0", pc, redir_pend, 32'h3100); end
  endtask

  task automatic test_exc_eret();
    idle(); stall = 1; br_taken = 1; br_target = 32'h3200;
    tick();
    checks++; if (redir_pend !== 1'b1) begin errors++; $display("FAIL exc_setup_pend got=%b want=1", redir_pend); end
    br_taken = 0; exc_enter = 1; eret = 1; epc = 32'h3020;
    tick(); idle();
    checks++; if (pc !== 32'h4180 || redir_pend !== 1'b0) begin errors++; $display("FAIL exc_enter got=%h/%b want=%h/0", pc, redir_pend, 32'h4180); end
    eret = 1; epc = 32'h3020;
    tick(); idle();
    checks++; if (pc !== 32'h3020) begin errors++; $display("FAIL eret_pc got=%h want=%h", pc, 32'h3020); end
    tick();
    checks++; if (pc !== 32'h3024) begin errors++; $display("FAIL eret_next got=%h want=%h", pc, 32'h3024); end
  endtask

  task automatic test_adel();
    logic [31:0] addrs [6];
    addrs[0] = 32'h3022; addrs[1] = 32'h7000; addrs[2] = 32'h6ffc;
    addrs[3] = 32'h2ffc; addrs[4] = 32'h3000; addrs[5] = 32'h6ffd;
    for (int i = 0; i < 6; i++) begin
      idle(); eret = 1; epc = addrs[i];
      tick(); idle();
      checks++;
      if (pc !== addrs[i] || fetch_exc !== exp_adel(addrs[i]) ||
          fetch_exccode !== (exp_adel(addrs[i]) ? 5'd4 : 5'd0)) begin
        errors++;
        $display("FAIL adel_%h got=%h/%b/%0d want=%h/%b/%0d", addrs[i], pc, fetch_exc, fetch_exccode,
                 addrs[i], exp_adel(addrs[i]), exp_adel(addrs[i]) ? 4 : 0);
      end
    end
  endtask

  task automatic test_wrap();
    idle(); eret = 1; epc = 32'hffff_fffc;
    tick(); idle();
    checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h want=0", pc4); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h want=0", pc); end
  endtask

  task automatic test_async_reset();
    idle(); eret = 1; epc = 32'h3400;
    tick(); idle(); stall = 1; br_taken = 1; br_target = 32'h3300;
    tick();
    checks++; if (redir_pend !== 1'b1) begin errors++; $display("FAIL areset_setup got=%b want=1", redir_pend); end
    @(negedge clk); #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (pc !== 32'h3000 || pc4 !== 32'h3004) begin errors++; $display("FAIL areset_pc got=%h/%h want=%h/%h", pc, pc4, 32'h3000, 32'h3004); end
    checks++; if (redir_pend !== 1'b0 || fetch_exc !== 1'b0) begin errors++; $display("FAIL areset_flags got=%b/%b want=0/0", redir_pend, fetch_exc); end
    @(negedge clk);
    reset = 1'b0; idle();
    tick();
    checks++; if (pc !== 32'h3004 || redir_pend !== 1'b0) begin errors++; $display("FAIL areset_release got=%h/%b want=%h/0", pc, redir_pend, 32'h3004); end
  endtask

  task automatic test_random();
    int n_bad = 0;
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(0, 99) < 35);
      br_taken  = ($urandom_range(0, 99) < 30);
      exc_enter = ($urandom_range(0, 99) < 5);
      eret      = ($urandom_range(0, 99) < 6);
      br_target = ($urandom_range(0, 9) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 16383) << 2));
      epc       = ($urandom_range(0, 4) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 16383) << 2));
      tick();
      checks++;
      if (pc !== m_pc || pc4 !== m_pc + 32'd4 || redir_pend !== m_pend ||
          fetch_exc !== exp_adel(m_pc) || fetch_exccode !== (exp_adel(m_pc) ? 5'd4 : 5'd0)) begin
        errors++;
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL rand%0d got pc=%h pc4=%h pend=%b fexc=%b code=%0d want pc=%h pc4=%h pend=%b fexc=%b",
                   i, pc, pc4, redir_pend, fetch_exc, fetch_exccode, m_pc, m_pc + 32'd4, m_pend, exp_adel(m_pc));
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_exc_eret();
    test_adel();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_pc.md
# ifu_pc

Program-counter register and next-PC selector of the instruction-fetch stage. Holds the current fetch address, drives it to instruction memory and to the `pc_incr` adder, and selects each cycle among sequential, branch/jump redirect, exception entry and `eret` return. Sits at the head of the IF stage; its `pc4` feeds the IF/ID pipeline register and its `pc` feeds IM and CP0 (EPC source).

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_3000`: fetch address after reset.
- `EXC_VECTOR`, default `32'h0000_4180`: handler entry address.
- `IM_LO`, default `32'h0000_3000`: lowest legal fetch address.
- `IM_HI`, default `32'h0000_6ffc`: highest legal fetch address.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `stall`  in  1  hazard unit freeze of IF.
- `br_taken`  in  1  ID-stage branch/jump resolved taken.
- `br_target`  in  32  redirect address, valid with `br_taken`.
- `exc_enter`  in  1  CP0 requests exception/interrupt entry.
- `eret`  in  1  `eret` in ID; return to `epc`.
- `epc`  in  32  CP0 EPC value.
- `pc`  out  32  current fetch address (registered).
- `pc4`  out  32  `pc + 4` from `pc_incr`.
- `redir_pend`  out  1  a redirect is latched, waiting for the stall to drop.
- `fetch_exc`  out  1  current `pc` is an illegal fetch (AdEL).
- `fetch_exccode`  out  5  `5'd4` when `fetch_exc`, else 0.

## Operation

- Registers: `pc_q[31:0]`, `pend_q` (1 bit), `pend_tgt_q[31:0]`.
- Next-PC priority, highest first:
  1. `exc_enter`: `pc_q` <= `EXC_VECTOR`; clear `pend_q`. Ignores `stall`.
  2. `eret`: `pc_q` <= `epc`; clear `pend_q`. Ignores `stall`.
  3. `stall`: hold `pc_q`.
     - If `br_taken`, latch `br_target` into `pend_tgt_q` and set `pend_q`.
     - A later `br_taken` during the same stall overwrites the latched target.
  4. `br_taken`: `pc_q` <= `br_target`; clear `pend_q`. A fresh redirect overrides a pending one.
  5. `pend_q`: `pc_q` <= `pend_tgt_q`; clear `pend_q`.
  6. Otherwise: `pc_q` <= `pc4`.
- Arithmetic: `pc4` = `pc_q + 32'd4`, modulo 2^32. `32'hffff_fffc` wraps to 0 with no flag.
- `redir_pend` = `pend_q`.
- Simultaneous `exc_enter` and `eret`: `exc_enter` wins.

## Timing

- Reset (asynchronous): `pc_q` = `RESET_PC`, `pend_q` = 0, `pend_tgt_q` = 0. Outputs during reset: `pc` = `32'h3000`, `pc4` = `32'h3004`, `redir_pend` = 0, `fetch_exc` = 0.
- Reset asserted mid-stall with a redirect pending: the pending redirect is discarded.
- Latency: every control input sampled at edge N is visible on `pc` after edge N. `pc4` and `fetch_exc` are combinational from `pc_q`, valid in the same cycle.
- Pending redirect: applied on the first edge where `stall` is 0 and neither `exc_enter` nor `eret` is asserted, i.e. one cycle after the stall releases.
- No handshake; the caller guarantees `br_target` and `epc` are stable at the sampling edge.

## Configuration

- `IFU_ADEL_CHECK_EN` defined: `fetch_exc` = (`pc_q[1:0]` != 0) or (`pc_q` < `IM_LO`) or (`pc_q` > `IM_HI`); `fetch_exccode` = 4 when set. The flag is combinational, travels with the instruction, and does not itself alter the PC; CP0 returns `exc_enter`.
- Undefined: `fetch_exc` and `fetch_exccode` are tied to 0 and the range logic is absent.

## Structure

- Shared package `mips_pkg`: `RESET_PC`, `EXC_VECTOR`, `IM_LO`, `IM_HI` constants and `EXC_ADEL = 5'd4`.
- One sub-module, `pc_incr`: 32-bit +4 adder producing `pc4`.
- Priority mux and pending-redirect register stay in `ifu_pc`.

## Test plan

- Reset, release, 3 free cycles -> `pc` 3000, 3004, 3008, 300c.
- At `pc` = 300c, `br_taken` with target 3040 -> next `pc` = 3040, `redir_pend` stays 0.
- `stall` 2 cycles with `br_taken` (target 3100) in the first -> `pc` holds, `redir_pend` = 1; after release `pc` = 3100, `redir_pend` = 0.
- `exc_enter`, `eret` (`epc` = 3020) and `stall` together -> `pc` = 4180 and any pending redirect is cleared; then `eret` alone -> `pc` = 3020.
- With `IFU_ADEL_CHECK_EN`, `eret` to `epc` = 3022 -> `fetch_exc` = 1, `fetch_exccode` = 4. With `epc` = 7000 -> `fetch_exc` = 1. Macro off -> both 0.
- Assert `reset` asynchronously mid-cycle during a pending redirect -> `pc` = 3000 immediately, pending redirect is not applied after release.
